// File: rtl/mem_write_monitor_pkg.sv
// Shared types for the data-memory write monitor: mode codes, FSM states and
// the expected-write table entry.
package mem_write_monitor_pkg;

    // Table entries store addresses and data up to these widths.
    localparam int unsigned ENTRY_AW = 32;
    localparam int unsigned ENTRY_DW = 32;

    localparam logic [1:0] MODE_ORDERED = 2'd0;
    localparam logic [1:0] MODE_STRICT  = 2'd1;
    localparam logic [1:0] MODE_ANY     = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PASS = 2'd2,
        ST_FAIL = 2'd3
    } state_e;

    typedef struct packed {
        logic [ENTRY_AW-1:0] addr;
        logic [ENTRY_DW-1:0] data;
        logic                addr_care;
    } entry_t;

endpackage

// File: rtl/monitor_exp_table.sv
// Expected-write register file: one synchronous write port, one asynchronous
// read port, no reset so contents survive a monitor reset.
module monitor_exp_table
    import mem_write_monitor_pkg::*;
#(
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned IW    = $clog2(DEPTH)
) (
    input  logic          ph2,
    input  logic          we,
    input  logic [IW-1:0] wr_idx,
    input  entry_t        wr_entry,
    input  logic [IW-1:0] rd_idx,
    output entry_t        rd_entry_c
);

    entry_t mem_q [DEPTH];

    always_ff @(posedge ph2) begin
        if (we) begin
            mem_q[wr_idx] <= wr_entry;
        end
    end

    assign rd_entry_c = mem_q[rd_idx];

endmodule

// File: rtl/mem_write_monitor.sv
// Self-check monitor for the core's data-memory write port: compares observed
// writes against a programmed table and reports a pass/fail verdict.
module mem_write_monitor
    import mem_write_monitor_pkg::*;
#(
    parameter  int unsigned AW    = 32,
    parameter  int unsigned DW    = 32,
    parameter  int unsigned DEPTH = 8,
    parameter  int unsigned CW    = 32,
    parameter  int unsigned MW    = 8,
    localparam int unsigned IW    = $clog2(DEPTH)
) (
    input  logic          ph2,
    input  logic          reset,
    input  logic          start,
    input  logic [1:0]    mode,
    input  logic [IW:0]   num_exp,
    input  logic [CW-1:0] timeout_cycles,
    input  logic          cfg_we,
    input  logic [IW-1:0] cfg_idx,
    input  logic [AW-1:0] cfg_addr,
    input  logic [DW-1:0] cfg_data,
    input  logic          cfg_addr_care,
    input  logic          memwrite,
    input  logic [AW-1:0] dataadr,
    input  logic [DW-1:0] writedata,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [IW:0]   matched,
    output logic [MW-1:0] mismatches,
    output logic [CW-1:0] cycles,
    output logic [AW-1:0] bad_addr,
    output logic [DW-1:0] bad_data
);

    localparam logic [IW:0] DEPTH_L = (IW+1)'(DEPTH);

    state_e        state_q, state_d;
    logic [1:0]    mode_q, mode_d;
    logic [IW:0]   num_exp_q, num_exp_d;
    logic [CW-1:0] timeout_q, timeout_d;
    logic [IW:0]   matched_q, matched_d;
    logic [MW-1:0] mismatches_q, mismatches_d;
    logic [CW-1:0] cycles_q, cycles_d;
    logic [AW-1:0] bad_addr_q, bad_addr_d;
    logic [DW-1:0] bad_data_q, bad_data_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          pass_q, pass_d;

    logic          tbl_we_c;
    logic [IW-1:0] rd_idx_c;
    entry_t        wr_entry_c;
    entry_t        rd_entry_c;
    logic          hit_c;

    assign wr_entry_c = '{addr:      ENTRY_AW'(cfg_addr),
                          data:      ENTRY_DW'(cfg_data),
                          addr_care: cfg_addr_care};

    // ANY always compares against entry 0; other modes walk the table in order.
    assign rd_idx_c = (mode_q == MODE_ANY) ? '0 : matched_q[IW-1:0];

    assign hit_c = (writedata == DW'(rd_entry_c.data)) &&
                   (!rd_entry_c.addr_care || (dataadr == AW'(rd_entry_c.addr)));

    monitor_exp_table #(
        .DEPTH (DEPTH)
    ) u_table (
        .ph2        (ph2),
        .we         (tbl_we_c),
        .wr_idx     (cfg_idx),
        .wr_entry   (wr_entry_c),
        .rd_idx     (rd_idx_c),
        .rd_entry_c (rd_entry_c)
    );

    always_ff @(posedge ph2 or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            mode_q       <= MODE_ORDERED;
            num_exp_q    <= '0;
            timeout_q    <= '0;
            matched_q    <= '0;
            mismatches_q <= '0;
            cycles_q     <= '0;
            bad_addr_q   <= '0;
            bad_data_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            num_exp_q    <= num_exp_d;
            timeout_q    <= timeout_d;
            matched_q    <= matched_d;
            mismatches_q <= mismatches_d;
            cycles_q     <= cycles_d;
            bad_addr_q   <= bad_addr_d;
            bad_data_q   <= bad_data_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        num_exp_d    = num_exp_q;
        timeout_d    = timeout_q;
        matched_d    = matched_q;
        mismatches_d = mismatches_q;
        cycles_d     = cycles_q;
        bad_addr_d   = bad_addr_q;
        bad_data_d   = bad_data_q;
        tbl_we_c     = 1'b0;

        case (state_q)
            ST_IDLE, ST_PASS, ST_FAIL: begin
                tbl_we_c = cfg_we;
                if (start) begin
                    state_d      = ST_RUN;
                    mode_d       = mode;
                    num_exp_d    = (num_exp > DEPTH_L) ? DEPTH_L : num_exp;
                    timeout_d    = timeout_cycles;
                    matched_d    = '0;
                    mismatches_d = '0;
                    cycles_d     = '0;
                    bad_addr_d   = '0;
                    bad_data_d   = '0;
                end
            end
            ST_RUN: begin
                if (num_exp_q == '0) begin
                    state_d = ST_PASS;
                end else if (memwrite) begin
                    if (hit_c) begin
                        if (mode_q == MODE_ANY) begin
                            matched_d = (IW+1)'(1);
                            state_d   = ST_PASS;
                        end else begin
                            matched_d = matched_q + (IW+1)'(1);
                            if (matched_d == num_exp_q) begin
                                state_d = ST_PASS;
                            end
                        end
                    end else begin
                        if (mismatches_q != '1) begin
                            mismatches_d = mismatches_q + MW'(1);
                        end
                        bad_addr_d = dataadr;
                        bad_data_d = writedata;
                        if (mode_q == MODE_STRICT) begin
                            state_d = ST_FAIL;
                        end
                    end
                end
                // Timeout only applies when the compare did not already end the
                // session, so a completing hit on the same edge wins.
                if (state_d == ST_RUN) begin
                    if ((timeout_q != '0) && (cycles_q == timeout_q - CW'(1))) begin
                        state_d = ST_FAIL;
                    end else if (cycles_q != '1) begin
                        cycles_d = cycles_q + CW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_PASS) || (state_d == ST_FAIL);
        pass_d = (state_d == ST_PASS);
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign matched    = matched_q;
    assign mismatches = mismatches_q;
    assign cycles     = cycles_q;
    assign bad_addr   = bad_addr_q;
    assign bad_data   = bad_data_q;

endmodule

// File: tb/tb_mem_write_monitor.sv
// Directed bench for mem_write_monitor: a vector table for whole sessions plus
// hand-written sequences for timeout, reset and in-session corner cases.
module tb_mem_write_monitor;

    logic        ph2 = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  mode;
    logic [3:0]  num_exp;
    logic [31:0] timeout_cycles;
    logic        cfg_we;
    logic [2:0]  cfg_idx;
    logic [31:0] cfg_addr;
    logic [31:0] cfg_data;
    logic        cfg_addr_care;
    logic        memwrite;
    logic [31:0] dataadr;
    logic [31:0] writedata;
    logic        busy;
    logic        done;
    logic        pass;
    logic [3:0]  matched;
    logic [7:0]  mismatches;
    logic [31:0] cycles;
    logic [31:0] bad_addr;
    logic [31:0] bad_data;

    int checks   = 0;
    int failures = 0;

    mem_write_monitor dut (
        .ph2            (ph2),
        .reset          (reset),
        .start          (start),
        .mode           (mode),
        .num_exp        (num_exp),
        .timeout_cycles (timeout_cycles),
        .cfg_we         (cfg_we),
        .cfg_idx        (cfg_idx),
        .cfg_addr       (cfg_addr),
        .cfg_data       (cfg_data),
        .cfg_addr_care  (cfg_addr_care),
        .memwrite       (memwrite),
        .dataadr        (dataadr),
        .writedata      (writedata),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .matched        (matched),
        .mismatches     (mismatches),
        .cycles         (cycles),
        .bad_addr       (bad_addr),
        .bad_data       (bad_data)
    );

    always #5 ph2 = ~ph2;

    typedef struct {
        logic        start;
        logic [1:0]  mode;
        logic [3:0]  nexp;
        logic        cwe;
        logic [2:0]  cidx;
        logic [31:0] caddr;
        logic [31:0] cdata;
        logic        ccare;
        logic        mw;
        logic [31:0] adr;
        logic [31:0] wd;
        logic        e_busy;
        logic        e_done;
        logic        e_pass;
        logic [3:0]  e_m;
        logic [7:0]  e_mis;
        logic [31:0] e_ba;
        logic [31:0] e_bd;
    } vec_t;

    vec_t vq[$];
    vec_t cur;

    task automatic tick();
        @(posedge ph2);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [78:0] outs();
        return {busy, done, pass, matched, mismatches, bad_addr, bad_data};
    endfunction

    // Row builders: one input action per row, then the expected outputs.
    task automatic r_cfg(input logic [2:0] i, input logic [31:0] a, input logic [31:0] d, input logic c);
        cur = '{default: '0};
        cur.cwe = 1'b1; cur.cidx = i; cur.caddr = a; cur.cdata = d; cur.ccare = c;
    endtask

    task automatic r_start(input logic [1:0] md, input logic [3:0] ne);
        cur = '{default: '0};
        cur.start = 1'b1; cur.mode = md; cur.nexp = ne;
    endtask

    task automatic r_wr(input logic [31:0] a, input logic [31:0] d);
        cur = '{default: '0};
        cur.mw = 1'b1; cur.adr = a; cur.wd = d;
    endtask

    task automatic r_exp(input logic b, input logic dn, input logic p, input logic [3:0] m,
                         input logic [7:0] mis, input logic [31:0] ba, input logic [31:0] bd);
        cur.e_busy = b; cur.e_done = dn; cur.e_pass = p; cur.e_m = m;
        cur.e_mis = mis; cur.e_ba = ba; cur.e_bd = bd;
        vq.push_back(cur);
    endtask

    task automatic clear_inputs();
        start = 0; mode = 0; num_exp = 0; timeout_cycles = 0;
        cfg_we = 0; cfg_idx = 0; cfg_addr = 0; cfg_data = 0; cfg_addr_care = 0;
        memwrite = 0; dataadr = 0; writedata = 0;
    endtask

    task automatic start_sess(input logic [1:0] md, input logic [3:0] ne, input logic [31:0] to);
        start = 1; mode = md; num_exp = ne; timeout_cycles = to;
        tick();
        start = 0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        memwrite = 1; dataadr = a; writedata = d;
        tick();
        memwrite = 0;
    endtask

    task automatic prog(input logic [2:0] i, input logic [31:0] a, input logic [31:0] d, input logic c);
        cfg_we = 1; cfg_idx = i; cfg_addr = a; cfg_data = d; cfg_addr_care = c;
        tick();
        cfg_we = 0;
    endtask

    initial begin
        // ORDERED: one miss then the expected write
        r_cfg(3'd0, 32'h14, 32'd21, 1'b1);        r_exp(0, 0, 0, 0, 0, 0, 0);
        r_start(2'd0, 4'd1);                       r_exp(1, 0, 0, 0, 0, 0, 0);
        r_wr(32'h10, 32'd5);                       r_exp(1, 0, 0, 0, 1, 32'h10, 32'd5);
        r_wr(32'h14, 32'd21);                      r_exp(0, 1, 1, 1, 1, 32'h10, 32'd5);
        r_wr(32'h99, 32'd99);                      r_exp(0, 1, 1, 1, 1, 32'h10, 32'd5);
        // STRICT: first matches, second misses
        r_cfg(3'd0, 32'h204, 32'd7, 1'b1);         r_exp(0, 1, 1, 1, 1, 32'h10, 32'd5);
        r_cfg(3'd1, 32'h208, 32'd9, 1'b1);         r_exp(0, 1, 1, 1, 1, 32'h10, 32'd5);
        r_start(2'd1, 4'd2);                       r_exp(1, 0, 0, 0, 0, 0, 0);
        r_wr(32'h204, 32'd7);                      r_exp(1, 0, 0, 1, 0, 0, 0);
        r_wr(32'h300, 32'd1);                      r_exp(0, 1, 0, 1, 1, 32'h300, 32'd1);
        // ANY: address ignored, first hit passes
        r_cfg(3'd0, 32'hdeadbeef, 32'd479001600, 1'b0); r_exp(0, 1, 0, 1, 1, 32'h300, 32'd1);
        r_start(2'd2, 4'd3);                       r_exp(1, 0, 0, 0, 0, 0, 0);
        r_wr(32'h7ffffff0, 32'd1);                 r_exp(1, 0, 0, 0, 1, 32'h7ffffff0, 32'd1);
        r_wr(32'h7ffffff0, 32'd2);                 r_exp(1, 0, 0, 0, 2, 32'h7ffffff0, 32'd2);
        r_wr(32'h7ffffff0, 32'd479001600);         r_exp(0, 1, 1, 1, 2, 32'h7ffffff0, 32'd2);
        // Reserved mode 3 tolerates misses like ORDERED
        r_start(2'd3, 4'd2);                       r_exp(1, 0, 0, 0, 0, 0, 0);
        r_wr(32'h1, 32'd479001600);                r_exp(1, 0, 0, 1, 0, 0, 0);
        r_wr(32'h208, 32'd8);                      r_exp(1, 0, 0, 1, 1, 32'h208, 32'd8);
        r_wr(32'h208, 32'd9);                      r_exp(0, 1, 1, 2, 1, 32'h208, 32'd8);

        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        chk("reset_outs", {outs(), cycles}, '0);
        reset = 1'b0;

        foreach (vq[i]) begin
            start = vq[i].start; mode = vq[i].mode; num_exp = vq[i].nexp; timeout_cycles = 0;
            cfg_we = vq[i].cwe; cfg_idx = vq[i].cidx; cfg_addr = vq[i].caddr;
            cfg_data = vq[i].cdata; cfg_addr_care = vq[i].ccare;
            memwrite = vq[i].mw; dataadr = vq[i].adr; writedata = vq[i].wd;
            tick();
            chk($sformatf("vec%0d", i), outs(),
                {vq[i].e_busy, vq[i].e_done, vq[i].e_pass, vq[i].e_m, vq[i].e_mis,
                 vq[i].e_ba, vq[i].e_bd});
        end
        clear_inputs();

        // num_exp above DEPTH is clamped to 8
        for (int i = 0; i < 8; i++) prog(3'(i), 32'h0, 32'(100 + i), 1'b0);
        start_sess(2'd0, 4'd15, 32'd0);
        for (int i = 0; i < 7; i++) wr(32'h500, 32'(100 + i));
        chk("clamp_mid", {busy, matched}, {1'b1, 4'd7});
        wr(32'h500, 32'd107);
        chk("clamp_end", {done, pass, matched}, {1'b1, 1'b1, 4'd8});

        // Timeout with no writes
        prog(3'd0, 32'h40, 32'd55, 1'b1);
        start_sess(2'd0, 4'd1, 32'd10);
        repeat (9) tick();
        chk("tmo_before", {busy, done, cycles}, {1'b1, 1'b0, 32'd9});
        tick();
        chk("tmo_fail", {busy, done, pass, cycles}, {1'b0, 1'b1, 1'b0, 32'd9});

        // Completing hit on the timeout edge
        start_sess(2'd0, 4'd1, 32'd10);
        repeat (9) tick();
        wr(32'h40, 32'd55);
        chk("tmo_hit_wins", {done, pass, matched, cycles}, {1'b1, 1'b1, 4'd1, 32'd9});

        // STRICT miss on the timeout edge: data matches but address differs
        start_sess(2'd1, 4'd1, 32'd10);
        repeat (9) tick();
        wr(32'h44, 32'd55);
        chk("tmo_strict_miss", {done, pass, mismatches, bad_addr, bad_data},
            {1'b1, 1'b0, 8'd1, 32'h44, 32'd55});

        // num_exp=0 passes after one RUN cycle, ignoring its write
        start_sess(2'd0, 4'd0, 32'd0);
        chk("nexp0_run", {busy, done}, {1'b1, 1'b0});
        wr(32'h1, 32'd1);
        chk("nexp0_pass", {busy, done, pass, matched, mismatches}, {1'b0, 1'b1, 1'b1, 4'd0, 8'd0});

        // cfg_we and start during RUN are ignored
        start_sess(2'd0, 4'd1, 32'd0);
        repeat (3) tick();
        chk("run_cycles3", cycles, 32'd3);
        cfg_we = 1; cfg_idx = 0; cfg_addr = 32'h40; cfg_data = 32'd99; cfg_addr_care = 1;
        start = 1; mode = 2'd1; num_exp = 4'd2;
        tick();
        cfg_we = 0; start = 0;
        chk("start_in_run", {busy, cycles}, {1'b1, 32'd4});
        wr(32'h40, 32'd99);
        chk("cfg_in_run_miss", {busy, mismatches}, {1'b1, 8'd1});
        wr(32'h40, 32'd55);
        chk("cfg_in_run_pass", {done, pass, matched}, {1'b1, 1'b1, 4'd1});

        // Asynchronous reset at cycle 5 of RUN; table survives
        start_sess(2'd0, 4'd1, 32'd0);
        wr(32'h1, 32'd2);
        repeat (4) tick();
        chk("pre_reset", {busy, mismatches, cycles}, {1'b1, 8'd1, 32'd5});
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset", {outs(), cycles}, '0);
        @(posedge ph2);
        #1;
        reset = 1'b0;
        tick();
        chk("post_reset_idle", {outs(), cycles}, '0);
        start_sess(2'd0, 4'd1, 32'd0);
        wr(32'h40, 32'd55);
        chk("restart_pass", {done, pass, matched, mismatches}, {1'b1, 1'b1, 4'd1, 8'd0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
